q_desc_fifo: RTL and testbench
==============================

// Module: q_desc_fifo
// PURPOSE
//  Per-traffic-class packet-descriptor FIFO, one instance per class (TT, RC, BE, PCF).
//  Sits directly upstream of q_server_3_states: drives its cur_value (queued packet count)
//  and pkt_len (length of head packet), and pops one descriptor per grant on bool_go.
//  Descriptors are written by the ingress classifier via a single-cycle enqueue strobe.
// PARAMETERS
//  P_CLASS   2'b01  traffic-class code (00 PCF, 01 TT, 11 RC, 10 BE); exported on class_id
//  AW        4      address width; capacity = 2**AW descriptors (default 16)
//  LEN_W     8      descriptor (packet length) width
//  CNT_W     8      cur_value width; must satisfy 2**CNT_W > 2**AW
// PORTS
//  clk        in   1      system clock, all state updates on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  flush      in   1      synchronous clear of queue contents and sticky flags
//  enq        in   1      push strobe, one descriptor per high cycle
//  enq_len    in   LEN_W  length of descriptor being pushed
//  bool_go    in   1      grant/transmit level from q_server_3_states; rising edge pops head
//  cur_value  out  CNT_W  registered occupancy (number of stored descriptors)
//  pkt_len    out  LEN_W  registered length of head descriptor; 0 when empty
//  full       out  1      occupancy == 2**AW
//  empty      out  1      occupancy == 0
//  err_ovf    out  1      sticky: push attempted while full
//  err_udf    out  1      sticky: go rising edge while empty
//  err_zlen   out  1      sticky: push with enq_len == 0
//  class_id   out  2      constant P_CLASS
// BEHAVIOUR
//  Reset (rst_n low, async): rd/wr pointers 0, cur_value 0, pkt_len 0, empty 1, full 0,
//   all err_* 0, go-edge history register 0. Storage array not reset.
//  Pop event = bool_go high this cycle AND low last cycle (registered history bit).
//   A go level held for N cycles pops exactly one descriptor.
//  Push accepted iff enq & !full & (enq_len != 0).
//  Priority per cycle: flush > (push, pop evaluated together).
//  Flush: pointers/count to 0, pkt_len 0, err_* cleared; push/pop that cycle ignored;
//   the go-history register still samples bool_go, so a level high across flush
//   does not pop afterwards.
//  Latency: accepted push or pop is reflected on cur_value/pkt_len/full/empty in the
//   next cycle (all outputs registered, no combinational input-to-output path).
//  Simultaneous push+pop, count >= 1: count unchanged; head advances; if count == 1,
//   pkt_len becomes the newly pushed length.
//  Push into empty: pkt_len = enq_len next cycle.
//  Pop to empty: pkt_len = 0, empty = 1.
//  Push while full: dropped, err_ovf set; a simultaneous pop still executes.
//   Full + push + pop is therefore NOT an accepted push; count decrements.
//  Pop while empty: no state change except err_udf set.
//  Push with enq_len == 0: dropped, err_zlen set.
//  Pointers are AW bits and wrap modulo 2**AW; full/empty are derived from the
//   AW+1-bit count, never from pointer equality.
//  cur_value is zero-extended count; never exceeds 2**AW.
// STRUCTURE
//  q_pkg: class codes P_PCF/P_TT/P_RC/P_BE, default LEN_W, CNT_W.
//  Sub-module go_rise_det (clk, rst_n, level -> pulse): reused by q_server-side logic.
//  Storage: plain reg array, written on rising edge; head read from array at next rd_ptr.
// TESTING
//  1 Reset mid-traffic: 3 pushes, assert rst_n low for 7 cycles -> cur_value 0, pkt_len 0,
//    empty 1 asynchronously; no spurious pop on go already high at release.
//  2 Push lengths 4, 8, 3 -> cur_value 1,2,3 on successive cycles; pkt_len 4;
//    go high for 20 cycles -> exactly one pop: cur_value 2, pkt_len 8.
//  3 Fill 16 (lengths 1..16), push 17th -> full 1, err_ovf 1, cur_value 16;
//    pop all 16 -> pkt_len sequence 1..16 then 0, empty 1 (pointer wrap covered).
//  4 Count 1 (len 5), same cycle push len 9 + go rise -> cur_value 1, pkt_len 9.
//  5 Empty queue, go rise -> err_udf 1, cur_value 0; push len 0 -> err_zlen 1, count 0;
//    flush -> all err_* 0.
//  6 Full + push + go rise -> cur_value 15, err_ovf 1, head advanced by one.

Source files
------------

// File: rtl/q_pkg.sv
// Shared traffic-class codes and default widths for the per-class descriptor queues.
package q_pkg;
    localparam logic [1:0] P_PCF = 2'b00;
    localparam logic [1:0] P_TT  = 2'b01;
    localparam logic [1:0] P_RC  = 2'b11;
    localparam logic [1:0] P_BE  = 2'b10;

    localparam int LEN_W_DEF = 8;
    localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/go_rise_det.sv
// Rising-edge detector on a grant level; a level held high yields a single pulse.
module go_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);
    logic prev_q, prev_d;

    always_comb begin
        prev_d = level;
        pulse  = level & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= prev_d;
    end
endmodule

// File: rtl/q_desc_fifo.sv
// Per-class packet-descriptor FIFO feeding q_server_3_states: occupancy, head length,
// one pop per grant rising edge, sticky error flags.
module q_desc_fifo
    import q_pkg::*;
#(
    parameter logic [1:0] P_CLASS = P_TT,
    parameter int         AW      = 4,
    parameter int         LEN_W   = LEN_W_DEF,
    parameter int         CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             enq,
    input  logic [LEN_W-1:0] enq_len,
    input  logic             bool_go,
    output logic [CNT_W-1:0] cur_value,
    output logic [LEN_W-1:0] pkt_len,
    output logic             full,
    output logic             empty,
    output logic             err_ovf,
    output logic             err_udf,
    output logic             err_zlen,
    output logic [1:0]       class_id
);
    localparam int         DEPTH = 2**AW;
    localparam logic [AW:0] CAP  = {1'b1, {AW{1'b0}}};

    logic [LEN_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
    logic             err_ovf_q, err_ovf_d, err_udf_q, err_udf_d, err_zlen_q, err_zlen_d;
    logic             go_pulse, is_full, is_empty, push, pop;

    go_rise_det u_go_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .level (bool_go),
        .pulse (go_pulse)
    );

    assign is_full  = (count_q == CAP);
    assign is_empty = (count_q == '0);
    // Full-ness is judged before this cycle's pop, so full+push+pop drops the push.
    assign push     = enq & ~is_full & (enq_len != '0);
    assign pop      = go_pulse & ~is_empty;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        pkt_len_d  = pkt_len_q;
        err_ovf_d  = err_ovf_q;
        err_udf_d  = err_udf_q;
        err_zlen_d = err_zlen_q;

        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            pkt_len_d  = '0;
            err_ovf_d  = 1'b0;
            err_udf_d  = 1'b0;
            err_zlen_d = 1'b0;
        end else begin
            if (enq && is_full)           err_ovf_d  = 1'b1;
            if (enq && enq_len == '0)     err_zlen_d = 1'b1;
            if (go_pulse && is_empty)     err_udf_d  = 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

            // The new head is either an already-stored entry or the one being written now.
            if (count_d == '0)
                pkt_len_d = '0;
            else if (push && rd_ptr_d == wr_ptr_q)
                pkt_len_d = enq_len;
            else
                pkt_len_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= enq_len;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pkt_len_q  <= '0;
            err_ovf_q  <= 1'b0;
            err_udf_q  <= 1'b0;
            err_zlen_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pkt_len_q  <= pkt_len_d;
            err_ovf_q  <= err_ovf_d;
            err_udf_q  <= err_udf_d;
            err_zlen_q <= err_zlen_d;
        end
    end

    assign cur_value = CNT_W'(count_q);
    assign pkt_len   = pkt_len_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign err_ovf   = err_ovf_q;
    assign err_udf   = err_udf_q;
    assign err_zlen  = err_zlen_q;
    assign class_id  = P_CLASS;
endmodule

// File: tb/tb_q_desc_fifo.sv
// Directed and random stimulus against a queue-based reference of the descriptor FIFO.
module tb_q_desc_fifo;
    logic       clk = 1'b0;
    logic       rst_n, flush, enq, bool_go;
    logic [7:0] enq_len;
    logic [7:0] cur_value, pkt_len;
    logic       full, empty, err_ovf, err_udf, err_zlen;
    logic [1:0] class_id;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    int unsigned m_q[$];
    bit          m_go_prev, m_ovf, m_udf, m_zlen;

    always #5 clk = ~clk;

    q_desc_fifo dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .enq(enq), .enq_len(enq_len),
        .bool_go(bool_go), .cur_value(cur_value), .pkt_len(pkt_len), .full(full),
        .empty(empty), .err_ovf(err_ovf), .err_udf(err_udf), .err_zlen(err_zlen),
        .class_id(class_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".cur_value"}, 32'(cur_value), m_q.size());
        chk({tag, ".pkt_len"},   32'(pkt_len),   (m_q.size() == 0) ? 0 : m_q[0]);
        chk({tag, ".full"},      32'(full),      32'(m_q.size() == 16));
        chk({tag, ".empty"},     32'(empty),     32'(m_q.size() == 0));
        chk({tag, ".err_ovf"},   32'(err_ovf),   32'(m_ovf));
        chk({tag, ".err_udf"},   32'(err_udf),   32'(m_udf));
        chk({tag, ".err_zlen"},  32'(err_zlen),  32'(m_zlen));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_go_prev = 0; m_ovf = 0; m_udf = 0; m_zlen = 0;
    endtask

    // Applies the queue rules for one clock using the inputs present at the edge.
    task automatic model_step();
        bit rise, was_full, acc;
        rise      = bool_go && !m_go_prev;
        m_go_prev = bool_go;
        if (flush) begin
            m_q.delete();
            m_ovf = 0; m_udf = 0; m_zlen = 0;
            return;
        end
        was_full = (m_q.size() == 16);
        if (enq && was_full)            m_ovf  = 1;
        if (enq && enq_len == 0)        m_zlen = 1;
        if (rise && m_q.size() == 0)    m_udf  = 1;
        acc = enq && !was_full && enq_len != 0;
        if (rise && m_q.size() > 0) void'(m_q.pop_front());
        if (acc) m_q.push_back(enq_len);
    endtask

    // Drive at the falling edge, step the reference on the rising edge, check 1 unit later.
    task automatic cyc(input bit e, input int l, input bit g, input bit f, input string tag);
        enq = e; enq_len = 8'(l); bool_go = g; flush = f;
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        #1 chk_all(tag);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0; flush = 0; enq = 0; enq_len = 0; bool_go = 0;
        model_reset();
        #1 chk_all("por");
        chk("class_id", 32'(class_id), 32'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1;

        // 1: reset in the middle of traffic, go held high through release
        cyc(1, 7, 0, 0, "t1.push0");
        cyc(1, 9, 0, 0, "t1.push1");
        cyc(1, 2, 0, 0, "t1.push2");
        enq = 0; bool_go = 1;
        #2 rst_n = 0;
        model_reset();
        #1 chk_all("t1.async_rst");
        @(negedge clk);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, "t1.in_rst");
        rst_n = 1;
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, "t1.post_rst");
        cyc(0, 0, 0, 1, "t1.flush");

        // 2: three pushes, then a long grant pops exactly one
        cyc(1, 4, 0, 0, "t2.p4");
        cyc(1, 8, 0, 0, "t2.p8");
        cyc(1, 3, 0, 0, "t2.p3");
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, "t2.go_hold");
        chk("t2.cnt_after_go", 32'(cur_value), 32'd2);
        chk("t2.len_after_go", 32'(pkt_len), 32'd8);
        cyc(0, 0, 0, 1, "t2.flush");

        // 3: fill, overflow, drain with pointer wrap
        for (int i = 1; i <= 16; i++) cyc(1, i, 0, 0, "t3.fill");
        cyc(1, 99, 0, 0, "t3.ovf");
        chk("t3.full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 1, 0, "t3.pop");
            cyc(0, 0, 0, 0, "t3.gap");
        end
        chk("t3.empty", 32'(empty), 32'd1);
        cyc(0, 0, 0, 1, "t3.flush");

        // 4: single entry, simultaneous push + pop
        cyc(1, 5, 0, 0, "t4.p5");
        cyc(1, 9, 1, 0, "t4.pushpop");
        chk("t4.len9", 32'(pkt_len), 32'd9);
        cyc(0, 0, 0, 1, "t4.flush");

        // 5: underflow, zero-length push, flush clears flags
        cyc(0, 0, 1, 0, "t5.udf");
        cyc(1, 0, 0, 0, "t5.zlen");
        chk("t5.udf_set", 32'(err_udf), 32'd1);
        cyc(0, 0, 0, 1, "t5.flush");
        chk("t5.zlen_clr", 32'(err_zlen), 32'd0);

        // 6: full + push + pop drops the push, head advances
        for (int i = 1; i <= 16; i++) cyc(1, i + 20, 0, 0, "t6.fill");
        cyc(1, 77, 1, 0, "t6.full_pushpop");
        chk("t6.cnt15", 32'(cur_value), 32'd15);
        chk("t6.head", 32'(pkt_len), 32'd22);
        cyc(0, 0, 0, 1, "t6.flush");

        // Random traffic, occasional flush
        for (int i = 0; i < 400; i++)
            cyc(bit'($urandom_range(0, 2) != 0),
                ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255)),
                bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 63) == 0), "rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
